playlist_controller: RTL

Parametrised successor to the music player's fixed four-song control unit: sequences playback across `NUM_SONGS` songs with play/pause, next/previous, loop and shuffle modes, and fast-forward/rewind speed selection. Sits between the debounced front-panel buttons/switches and the song reader / note player. It drives the selected song index, the play enable, a one-cycle restart pulse for the song reader, and a playback-speed code.

---
 rtl/music_pkg.sv | 23 ++
 rtl/lfsr16.sv | 19 +
 rtl/playlist_controller.sv | 88 ++++++++
 3 files changed

// File: rtl/music_pkg.sv
// Shared definitions for the music player control path: state and speed
// encodings and the shuffle LFSR feedback taps.
package music_pkg;

    typedef enum logic {
        ST_PAUSED  = 1'b0,
        ST_PLAYING = 1'b1
    } state_t;

    localparam logic [1:0] SPEED_NORMAL = 2'b00;
    localparam logic [1:0] SPEED_FF     = 2'b01;
    localparam logic [1:0] SPEED_REW    = 2'b10;

    // x^16 + x^14 + x^13 + x^11 + 1, as a mask over q[15:0]
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [1:0] speed_code(input logic ff, input logic rw);
        if (ff && !rw)      return SPEED_FF;
        else if (rw && !ff) return SPEED_REW;
        else                return SPEED_NORMAL;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; loads seed on reset and steps every cycle.
module lfsr16
    import music_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic fb;
    assign fb = ^(q & LFSR_TAPS);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) q <= seed;
        else        q <= {q[14:0], fb};
    end

endmodule

// File: rtl/playlist_controller.sv
// Playlist sequencer: play/pause, next/prev, loop and shuffle, speed select.
// All outputs are registered; song_reset pulses alongside each index change.
module playlist_controller
    import music_pkg::*;
#(
    parameter int          NUM_SONGS = 4,
    parameter int          SONG_W    = $clog2(NUM_SONGS),
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play_button,
    input  logic              next_button,
    input  logic              prev_button,
    input  logic              song_done,
    input  logic              loop_mode,
    input  logic              shuffle_mode,
    input  logic              ff_switch0,
    input  logic              r_switch1,
    output logic [SONG_W-1:0] current_song,
    output logic              play,
    output logic              song_reset,
    output logic [1:0]        speed
);

    localparam logic [SONG_W-1:0] LAST = SONG_W'(NUM_SONGS - 1);

    state_t             state, state_nxt;
    logic [15:0]        lfsr_q;
    logic [SONG_W-1:0]  cand, seq_next, next_idx, prev_idx;
    logic               shuf_ok, end_of_list;
    logic               unused_lfsr;

    lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .seed  (LFSR_SEED),
        .q     (lfsr_q)
    );

    assign cand        = lfsr_q[SONG_W-1:0];
    assign unused_lfsr = ^lfsr_q[15:SONG_W];

    // A shuffle candidate out of range or equal to the current song falls back
    // to the sequential successor, so shuffle never repeats a song.
    always_comb begin
        seq_next = (current_song == LAST) ? '0 : current_song + 1'b1;
        prev_idx = (current_song == '0) ? LAST : current_song - 1'b1;
        shuf_ok  = (32'(cand) < NUM_SONGS) && (cand != current_song);
        next_idx = (shuffle_mode && shuf_ok) ? cand : seq_next;
    end

    assign end_of_list = song_done && !next_button && !prev_button &&
                         (current_song == LAST) && !loop_mode && !shuffle_mode;

    always_comb begin
        state_nxt = state;
        if (end_of_list)      state_nxt = ST_PAUSED;
        else if (play_button) state_nxt = (state == ST_PLAYING) ? ST_PAUSED : ST_PLAYING;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_PAUSED;
            current_song <= '0;
            play         <= 1'b0;
            song_reset   <= 1'b0;
            speed        <= SPEED_NORMAL;
        end else begin
            song_reset <= 1'b0;
            if (next_button) begin
                current_song <= next_idx;
                song_reset   <= 1'b1;
            end else if (prev_button) begin
                current_song <= prev_idx;
                song_reset   <= 1'b1;
            end else if (song_done) begin
                current_song <= end_of_list ? '0 : next_idx;
                song_reset   <= 1'b1;
            end
            state <= state_nxt;
            play  <= (state_nxt == ST_PLAYING);
            speed <= (state_nxt == ST_PLAYING) ? speed_code(ff_switch0, r_switch1)
                                               : SPEED_NORMAL;
        end
    end

endmodule
